// File: rtl/conv_pkg.sv
// conv_pkg: types and constants shared by the convolution operator and its
// stream driver.
//   WIDTH       - bits per sample / kernel coefficient
//   LEN         - number of taps (window length)
//   data_vector - LEN elements; data[0] is the oldest sample / first tap
//   result_t    - dot-product result, wide enough for LEN full-scale products
//   drv_state_t - stream driver FSM states
package conv_pkg;

    localparam int WIDTH = 8;
    localparam int LEN   = 4;
    localparam int RES_W = 2 * WIDTH + $clog2(LEN);

    typedef logic [WIDTH-1:0] data_t;

    typedef struct packed {
        data_t [LEN-1:0] data;
    } data_vector;

    typedef logic [RES_W-1:0] result_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } drv_state_t;

endpackage

// File: rtl/conv_result_skid.sv
// conv_result_skid: single-entry result register with valid/ready on both
// sides.
//   clk, rst             - clock, synchronous active-high reset
//   in_data/in_valid     - result offered by the driver
//   in_ready             - register is empty or is being drained this cycle
//   out_data/out_valid   - buffered result
//   out_ready            - downstream accepts out_data
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must stay high with stable data until that transfer.
module conv_result_skid
    import conv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  result_t in_data,
    input  logic    in_valid,
    output logic    in_ready,
    output result_t out_data,
    output logic    out_valid,
    input  logic    out_ready
);

    // Drain and reload in the same cycle keep the entry full with new data.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_stream_driver.sv
// conv_stream_driver: feeds the convolution operator from a serial sample
// stream. Keeps a sliding window of LEN samples and a latched kernel, issues
// (kernel, window) pairs to the operator, and buffers each result.
//   clk, rst                       - clock, synchronous active-high reset
//   kernel_in/kernel_load          - kernel write, accepted while kernel_ready
//   sample_in/sample_valid         - input stream, accepted while sample_ready
//   flush                          - restart the window fill
//   op_kernel/op_data/op_in_valid  - request to operator (op_in_ready)
//   op_result/op_out_valid         - result from operator (op_out_ready)
//   result_out/result_valid        - buffered result (result_ready)
//   state_dbg                      - current FSM state
//
// Handshake: every valid/ready pair transfers on a rising edge where both are
// high; a valid, once raised, stays high with stable payload until then.
module conv_stream_driver
    import conv_pkg::*;
#(
    parameter int STRIDE = 1,
    parameter int CNT_W  = $clog2(LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  data_vector kernel_in,
    input  logic       kernel_load,
    output logic       kernel_ready,
    input  data_t      sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       flush,
    output data_vector op_kernel,
    output data_vector op_data,
    output logic       op_in_valid,
    input  logic       op_in_ready,
    input  result_t    op_result,
    input  logic       op_out_valid,
    output logic       op_out_ready,
    output result_t    result_out,
    output logic       result_valid,
    input  logic       result_ready,
    output drv_state_t state_dbg
);

    drv_state_t       state, state_nxt;
    data_vector       window_q;
    data_vector       kernel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] need;
    logic             first_q;
    logic             flush_pend_q;
    logic             sample_take;
    logic             window_done;
    logic             result_take;
    logic             skid_in_ready;

    // The first window after reset/flush needs a full fill; later ones only
    // need STRIDE fresh samples.
    assign need = first_q ? CNT_W'(LEN) : CNT_W'(STRIDE);

    assign op_kernel = kernel_q;
    assign op_data   = window_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        kernel_ready = 1'b0;
        op_in_valid  = 1'b0;
        op_out_ready = 1'b0;
        sample_take  = 1'b0;
        window_done  = 1'b0;
        result_take  = 1'b0;
        case (state)
            FILL: begin
                kernel_ready = 1'b1;
                // flush has priority: the sample offered alongside it stays put.
                sample_ready = ~flush;
                sample_take  = sample_valid & ~flush;
                window_done  = sample_take && (cnt_q + CNT_W'(1) == need);
                if (window_done) state_nxt = ISSUE;
            end
            ISSUE: begin
                op_in_valid = 1'b1;
                if (op_in_ready) state_nxt = WAIT;
            end
            WAIT: begin
                op_out_ready = skid_in_ready;
                result_take  = op_out_valid & skid_in_ready;
                if (result_take) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q     <= '0;
            kernel_q     <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b1;
            flush_pend_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    // A load in the window-completing cycle lands in kernel_q on
                    // the same edge, so the issued pair already uses it.
                    if (kernel_load) kernel_q <= kernel_in;
                    if (flush) begin
                        cnt_q    <= '0;
                        first_q  <= 1'b1;
                        window_q <= '0;
                    end else if (sample_take) begin
                        for (int i = 0; i < LEN - 1; i++) begin
                            window_q.data[i] <= window_q.data[i+1];
                        end
                        window_q.data[LEN-1] <= sample_in;
                        cnt_q <= window_done ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (flush) flush_pend_q <= 1'b1;
                end
                WAIT: begin
                    if (result_take) begin
                        // A flush seen while busy takes effect only now, after
                        // the in-flight result has been collected.
                        if (flush || flush_pend_q) begin
                            first_q      <= 1'b1;
                            window_q     <= '0;
                            cnt_q        <= '0;
                            flush_pend_q <= 1'b0;
                        end else begin
                            first_q <= 1'b0;
                        end
                    end else if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    conv_result_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (op_result),
        .in_valid  (result_take),
        .in_ready  (skid_in_ready),
        .out_data  (result_out),
        .out_valid (result_valid),
        .out_ready (result_ready)
    );

endmodule
